// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-path constants and the default-width queue entry shape.
package cpu_pkg;
  localparam int CPU_DATA_W = 32;
  localparam int CPU_PC_W   = 32;
  localparam int CPU_EXC_W  = 5;
  localparam logic [CPU_EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [CPU_EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [CPU_PC_W-1:0]  BUBBLE_PC = '1;
  typedef struct packed {
    logic [CPU_DATA_W-1:0] data;
    logic [CPU_PC_W-1:0]   pc;
    logic [CPU_EXC_W-1:0]  exc;
  } fetch_entry_t;
endpackage

// File: rtl/fdq_ptr.sv
// fdq_ptr: modulo-DEPTH wrap-around pointer with increment enable and synchronous clear.
module fdq_ptr #(
  parameter int DEPTH = 2,
  localparam int W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);
  logic [W-1:0] r_ptr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_ptr <= '0;
    else if (i_clr) r_ptr <= '0;
    else if (i_inc) r_ptr <= (r_ptr == W'(DEPTH - 1)) ? '0 : r_ptr + W'(1);
  assign o_ptr = r_ptr;
endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: DEPTH-entry circular buffer between fetch and decode with
// valid/ready on both sides, synchronous flush and branch-delay-slot tracking.
module fetch_decode_queue #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int EXC_W  = 5,
  parameter int DEPTH  = 2,
  parameter logic [PC_W-1:0]  BUBBLE_PC = '1,
  parameter logic [EXC_W-1:0] EXC_ADEL  = EXC_W'(cpu_pkg::EXC_ADEL)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_pc_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  input  logic              dn_is_cti
);
  import cpu_pkg::*;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
    logic [EXC_W-1:0]  exc;
  } entry_t;
  entry_t        r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic          r_last_cti;
  logic [PW-1:0] w_rd, w_wr;
  logic          w_push, w_pop;
  entry_t        w_head;
  assign in_ready  = r_count != CW'(DEPTH);
  assign out_valid = r_count != '0;
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;
  fdq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (.clk(clk), .reset_n(reset_n), .i_clr(flush), .i_inc(w_pop), .o_ptr(w_rd));
  fdq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (.clk(clk), .reset_n(reset_n), .i_clr(flush), .i_inc(w_push), .o_ptr(w_wr));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_count    <= '0;
      r_last_cti <= 1'b0;
    end else if (flush) begin
      r_count    <= '0;
      r_last_cti <= 1'b0;
    end else begin
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_pop) r_last_cti <= dn_is_cti;
    end
  // Storage is left unreset; every read is masked by out_valid below.
  always_ff @(posedge clk)
    if (w_push) r_mem[w_wr] <= '{data: in_data, pc: in_pc, exc: in_pc_err ? EXC_ADEL : EXC_W'(EXC_NONE)};
  assign w_head   = r_mem[w_rd];
  assign out_data = out_valid ? w_head.data : '0;
  assign out_pc   = out_valid ? w_head.pc : BUBBLE_PC;
  assign out_exc  = out_valid ? w_head.exc : '0;
  assign out_bd   = out_valid & r_last_cti;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: scoreboard bench for fetch_decode_queue at DEPTH=3.
module tb_fetch_decode_queue;
  import cpu_pkg::*;
  localparam int DEPTH = 3;
  logic        clk = 0, reset_n = 0, flush = 0, in_valid = 0, in_pc_err = 0, out_ready = 0, dn_is_cti = 0;
  logic [31:0] in_data = '0, in_pc = '0;
  logic        in_ready, out_valid, out_bd;
  logic [31:0] out_data, out_pc;
  logic [4:0]  out_exc;
  fetch_entry_t sb[$];
  logic        m_bd = 0;
  int          n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  fetch_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_pc(in_pc), .in_pc_err(in_pc_err), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc), .out_exc(out_exc),
    .out_bd(out_bd), .dn_is_cti(dn_is_cti)
  );
  function automatic logic [31:0] dat(logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Check outputs at the falling edge against the model, then drive this cycle and advance the model.
  task automatic step(logic v, logic [31:0] pc, logic err, logic ordy, logic cti, logic fl);
    bit mv, pu, po;
    @(negedge clk);
    mv = sb.size() != 0;
    check("out_valid", out_valid, mv);
    check("in_ready", in_ready, sb.size() != DEPTH);
    check("count", dut.r_count, sb.size());
    if (mv) begin
      check("out_pc", out_pc, sb[0].pc);
      check("out_data", out_data, sb[0].data);
      check("out_exc", out_exc, sb[0].exc);
      check("out_bd", out_bd, m_bd);
    end else begin
      check("bubble_pc", out_pc, 32'hFFFF_FFFF);
      check("bubble_data", out_data, 0);
      check("bubble_exc", out_exc, 0);
      check("bubble_bd", out_bd, 0);
    end
    in_valid = v; in_pc = pc; in_data = dat(pc); in_pc_err = err;
    out_ready = ordy; dn_is_cti = cti; flush = fl;
    pu = v && sb.size() != DEPTH && !fl;
    po = mv && ordy && !fl;
    if (fl) begin
      sb.delete();
      m_bd = 0;
    end else begin
      if (po) begin
        void'(sb.pop_front());
        m_bd = cti;
      end
      if (pu) sb.push_back('{data: dat(pc), pc: pc, exc: err ? EXC_ADEL : EXC_NONE});
    end
  endtask
  task automatic drain();
    repeat (4) step(0, 0, 0, 1, 0, 0);
  endtask
  initial begin
    #12 reset_n = 1;
    step(0, 0, 0, 0, 0, 0);
    // reset mid-stream
    step(1, 32'h1000, 0, 0, 0, 0);
    step(1, 32'h1004, 0, 0, 0, 0);
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_pc", out_pc, 32'hFFFF_FFFF);
    sb.delete();
    m_bd = 0;
    #1 reset_n = 1;
    step(1, 32'h3000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("lat_pc", out_pc, 32'h3000);
    drain();
    // fill, stall, drain
    step(1, 32'h3000, 0, 0, 0, 0);
    step(1, 32'h3004, 0, 0, 0, 0);
    step(1, 32'h3008, 0, 0, 0, 0);
    step(1, 32'hDEAD, 0, 0, 0, 0);
    check("full_ready", in_ready, 0);
    drain();
    // simultaneous push/pop at count=1
    step(1, 32'h4000, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) step(1, 32'h4000 + 32'(4 * i), 0, 1, 0, 0);
    drain();
    // exception tag
    step(1, 32'h2FFC, 0, 0, 0, 0);
    step(1, 32'h3001, 1, 0, 0, 0);
    step(1, 32'h3004, 0, 0, 0, 0);
    drain();
    // delay slot
    step(1, 32'h5000, 0, 0, 0, 0);
    step(1, 32'h5004, 0, 0, 0, 0);
    step(1, 32'h5008, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    check("bd_set", out_bd, 1);
    step(0, 0, 0, 0, 0, 0);
    check("bd_clear", out_bd, 0);
    drain();
    // flush priority at count=2 with last_cti set
    step(1, 32'h6000, 0, 0, 0, 0);
    step(1, 32'h6004, 0, 0, 0, 0);
    step(1, 32'h6008, 0, 1, 1, 0);
    step(1, 32'h7777, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0);
    check("flush_valid", out_valid, 0);
    check("flush_bd", out_bd, 0);
    step(1, 32'h8000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("flush_next_pc", out_pc, 32'h8000);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Parametrised fetch-to-decode pipeline buffer replacing the single-entry fetch/decode latch. It holds up to DEPTH fetched instructions in a circular queue with valid/ready handshakes on both sides, plus synchronous flush. Each instruction carries its PC, a fetch exception code and a branch-delay-slot flag. It sits between the instruction-memory stage and the decode stage.

## Interface
Parameters:
- DATA_W, 32, instruction width
- PC_W, 32, PC width
- EXC_W, 5, exception-code width
- DEPTH, 2, queue entries; legal range 2..16
- BUBBLE_PC, all ones, PC presented while the output is empty
- EXC_ADEL, 4, code emitted for a fetch address error

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries and of BD history
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue accepts; registered, equals count != DEPTH
- in_data  in  DATA_W  fetched instruction
- in_pc  in  PC_W  fetch PC
- in_pc_err  in  1  fetch address error
- out_valid  out  1  head entry present; equals count != 0
- out_ready  in  1  decode consumes head
- out_data  out  DATA_W  head instruction; 0 when empty
- out_pc  out  PC_W  head PC; BUBBLE_PC when empty
- out_exc  out  EXC_W  head exception; 0 when empty
- out_bd  out  1  head is in a delay slot; 0 when empty
- dn_is_cti  in  1  decoder flag: current out_data is a branch or jump

## Operation
- Push: in_valid & in_ready. Store {in_data, in_pc, in_pc_err ? EXC_ADEL : 0} at wr_ptr, then advance wr_ptr.
- Pop: out_valid & out_ready. Advance rd_ptr. Load last_cti <= dn_is_cti.
- out_bd = out_valid & last_cti. The BD flag belongs to the instruction that follows a consumed control-transfer instruction.
- Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- count has width clog2(DEPTH+1).
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full: in_ready=0, so in_valid is ignored. Push and pop cannot coincide while full.
- Empty: out_valid=0, out_ready is ignored, and outputs show bubble values.
- No bypass: a pushed entry first appears at the output on the next cycle.
- flush has priority over everything:
  - count, rd_ptr, wr_ptr and last_cti all go to 0.
  - A same-cycle push is dropped.
  - A same-cycle pop does not update last_cti.
- Storage array is not reset. Outputs are masked by out_valid.
- Reset (asynchronous, any time, including mid-stream):
  - count=0, pointers=0, last_cti=0.
  - Outputs immediately become out_valid=0, in_ready=1, out_data=0, out_pc=BUBBLE_PC, out_exc=0, out_bd=0.

## Timing
- Input-to-output latency is 1 cycle when the queue is empty. Throughput is 1 instruction per cycle in steady state.
- in_ready and out_valid are pure register outputs; there is no combinational path from any input.
- out_data, out_pc and out_exc are driven from the entry at rd_ptr, muxed with bubble values on !out_valid. The path runs from registers only.
- out_bd depends only on registers.
- dn_is_cti is sampled only on the pop edge.
- Flush takes effect on the edge where it is sampled. On the next cycle out_valid=0 and in_ready=1.

## Structure
- Shared package `cpu_pkg`:
  - EXC_ADEL and EXC_NONE exception codes
  - BUBBLE_PC default
  - packed entry typedef {data, pc, exc}
- One sub-module, `fdq_ptr`: a wrap-around pointer with increment enable and synchronous clear. It is instantiated for rd_ptr and for wr_ptr.
- count update, last_cti register, output bubble mux and entry array live in the top level.

## Test plan
- Reset mid-stream:
  - Stimulus: push 2 entries, then drop reset_n between clock edges.
  - Required response: out_valid=0, in_ready=1 and out_pc=FFFFFFFF at once.
  - Then: after release, push of PC 0x3000 shows out_pc=0x3000 one cycle later.
- Fill, stall and drain (DEPTH=3):
  - Stimulus: out_ready=0, push 0x3000/0x3004/0x3008.
  - Required response: in_ready=0 after the 3rd push.
  - Then: with out_ready=1, pops return 0x3000, 0x3004, 0x3008 in order, then the queue is empty.
- Simultaneous push and pop at count=1 for 10 cycles: count stays 1, pointers wrap correctly, and PCs leave in order.
- Exception tag: push with in_pc_err=1 and PC 0x3001 gives out_exc=4 at that entry; neighbouring entries show out_exc=0.
- Delay slot:
  - Stimulus: pop an entry with dn_is_cti=1.
  - Required response: the next head has out_bd=1.
  - Then: pop it with dn_is_cti=0; the following head has out_bd=0.
- Flush priority:
  - Stimulus: at count=2, assert flush with in_valid=1, out_ready=1 and dn_is_cti=1.
  - Required response: the next cycle shows out_valid=0, out_bd=0 and count=0, and the pushed entry never appears.
